phy_tx_arbiter: RTL and testbench

- Transmit-side scheduler in front of the phy. It shares the phy's two 8-bit parallel lanes among four producer FIFOs.
- After reset it runs a link-init phase: both lanes are held idle, so the phy sends COM (0xBC) and the remote receiver reaches active.
- It then round-robin grants up to two FIFOs per clk_2f cycle, one per lane, and honours per-lane pause (almost-full) backpressure.
- Outputs feed the phy's data_in0/valid_in0 and data_in1/valid_in1.

---
 rtl/phy_pkg.sv | 19 +
 rtl/rr_pick4.sv | 25 ++
 rtl/phy_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_phy_tx_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared encodings and constants for the phy transmit arbiter
package phy_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    localparam logic [7:0] PHY_COM   = 8'hBC;
    localparam int         PHY_DW    = 8;
    localparam int         PHY_N_REQ = 4;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - first eligible request among four, searching upward from a start index
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [3:0] mask_i,
    input  logic [1:0] start_i,
    output logic       found_o,
    output logic [1:0] idx_o
);

    logic [3:0] elig;
    assign elig = req_i & ~mask_i;

    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = start_i;
        for (int i = 3; i >= 0; i--) begin
            if (elig[start_i + 2'(i)]) begin
                found_o = 1'b1;
                idx_o   = start_i + 2'(i);
            end
        end
    end

endmodule

// File: rtl/phy_tx_arbiter.sv
// rtl/phy_tx_arbiter.sv - link-init FSM and two-lane round-robin scheduler feeding the phy
module phy_tx_arbiter
    import phy_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int INIT_CYCLES = 8,
    parameter int DW          = 8
) (
    input  logic            clk_2f,
    input  logic            reset,
    input  logic            enable,
    input  logic [3:0]      fifo_empty,
    input  logic [4*DW-1:0] fifo_data,
    input  logic [1:0]      pause,
    output logic [3:0]      fifo_pop,
    output logic [DW-1:0]   data_out_0,
    output logic [DW-1:0]   data_out_1,
    output logic            valid_out_0,
    output logic            valid_out_1,
    output logic [1:0]      state
);

    localparam int CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_e          state_q;
    logic [CW-1:0]   init_cnt_q;
    logic [1:0]      rr_ptr_q;
    logic [1:0]      rr_ptr_d;
    logic [DW-1:0]   data0_q;
    logic [DW-1:0]   data1_q;
    logic            valid0_q;
    logic            valid1_q;

    logic            active;
    logic [3:0]      cand;
    logic            f0;
    logic            f1;
    logic [1:0]      i0;
    logic [1:0]      i1;
    logic            g0_v;
    logic            g1_v;
    logic [3:0]      mask1;
    logic [1:0]      start1;

    assign active = (state_q == ST_ACTIVE);
    assign cand   = ~fifo_empty;

    rr_pick4 u_lane0 (
        .req_i   (cand),
        .mask_i  (4'b0000),
        .start_i (rr_ptr_q),
        .found_o (f0),
        .idx_o   (i0)
    );

    assign g0_v   = active & ~pause[0] & f0;
    // Lane 1 continues the rotation just past lane 0's winner so one requester never takes both lanes.
    assign mask1  = g0_v ? onehot4(i0) : 4'b0000;
    assign start1 = g0_v ? (i0 + 2'd1) : rr_ptr_q;

    rr_pick4 u_lane1 (
        .req_i   (cand),
        .mask_i  (mask1),
        .start_i (start1),
        .found_o (f1),
        .idx_o   (i1)
    );

    assign g1_v = active & ~pause[1] & f1;

    always_comb begin
        fifo_pop = 4'b0000;
        if (g0_v) fifo_pop = fifo_pop | onehot4(i0);
        if (g1_v) fifo_pop = fifo_pop | onehot4(i1);
        rr_ptr_d = rr_ptr_q;
        if (g1_v)      rr_ptr_d = i1 + 2'd1;
        else if (g0_v) rr_ptr_d = i0 + 2'd1;
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
            rr_ptr_q   <= 2'd0;
            data0_q    <= '0;
            data1_q    <= '0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            data0_q  <= g0_v ? fifo_data[32'(i0)*DW +: DW] : '0;
            data1_q  <= g1_v ? fifo_data[32'(i1)*DW +: DW] : '0;
            valid0_q <= g0_v;
            valid1_q <= g1_v;
            rr_ptr_q <= rr_ptr_d;
            case (state_q)
                ST_RESET: begin
                    state_q    <= ST_INIT;
                    init_cnt_q <= '0;
                end
                ST_INIT: begin
                    if (init_cnt_q == CW'(INIT_CYCLES - 1)) begin
                        init_cnt_q <= '0;
                        state_q    <= enable ? ST_ACTIVE : ST_IDLE;
                    end else begin
                        init_cnt_q <= init_cnt_q + CW'(1);
                    end
                end
                ST_IDLE:   if (enable)  state_q <= ST_ACTIVE;
                ST_ACTIVE: if (!enable) state_q <= ST_IDLE;
                default:   state_q <= ST_RESET;
            endcase
        end
    end

    assign data_out_0  = data0_q;
    assign data_out_1  = data1_q;
    assign valid_out_0 = valid0_q;
    assign valid_out_1 = valid1_q;
    assign state       = state_q;

    a_cfg: assert property (@(posedge clk_2f) (N_REQ == PHY_N_REQ) && (INIT_CYCLES >= 4));

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// tb/tb_phy_tx_arbiter.sv - scoreboard bench for phy_tx_arbiter
module tb_phy_tx_arbiter;

    localparam logic [31:0] D   = 32'h40302010;
    localparam logic [8:0]  NO  = 9'h000;
    localparam logic [3:0]  ALL = 4'h0;
    localparam logic [3:0]  NON = 4'hF;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_data;
    logic [1:0]  pause;
    logic [3:0]  fifo_pop;
    logic [7:0]  data_out_0;
    logic [7:0]  data_out_1;
    logic        valid_out_0;
    logic        valid_out_1;
    logic [1:0]  state;

    int passed = 0;
    int total  = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    phy_tx_arbiter dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .pause       (pause),
        .fifo_pop    (fifo_pop),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .state       (state)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk_2f) begin
        if (valid_out_0 === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL lane0_unexpected actual=%h required=none at %0t", data_out_0, $time);
            end else chk("lane0_data", {24'h0, data_out_0}, {24'h0, q0.pop_front()});
        end
        if (valid_out_1 === 1'b1) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL lane1_unexpected actual=%h required=none at %0t", data_out_1, $time);
            end else chk("lane1_data", {24'h0, data_out_1}, {24'h0, q1.pop_front()});
        end
    end

    // Drive one cycle's inputs, check the combinational/state view, queue the words expected next edge.
    task automatic cyc(input logic en, input logic [3:0] emp, input logic [31:0] dat,
                       input logic [1:0] pz, input logic [3:0] ep, input logic [1:0] es,
                       input logic [8:0] e0, input logic [8:0] e1);
        enable     = en;
        fifo_empty = emp;
        fifo_data  = dat;
        pause      = pz;
        #1;
        chk("state", {30'h0, state}, {30'h0, es});
        chk("fifo_pop", {28'h0, fifo_pop}, {28'h0, ep});
        if (e0[8]) q0.push_back(e0[7:0]);
        if (e1[8]) q1.push_back(e1[7:0]);
        @(posedge clk_2f);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, {30'h0, state}, 32'h0);
        chk({tag, "_valids"}, {30'h0, valid_out_1, valid_out_0}, 32'h0);
        chk({tag, "_data"}, {16'h0, data_out_1, data_out_0}, 32'h0);
        chk({tag, "_pop"}, {28'h0, fifo_pop}, 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        enable     = 1'b1;
        fifo_empty = ALL;
        fifo_data  = D;
        pause      = 2'b00;
        repeat (3) @(posedge clk_2f);
        #1;
        chk_quiet("reset");
        reset = 1'b1;

        cyc(1, ALL, D, 2'b00, 4'b0000, 2'd0, NO, NO);
        for (int i = 0; i < 8; i++) cyc(1, ALL, D, 2'b00, 4'b0000, 2'd1, NO, NO);

        cyc(1, ALL, D, 2'b00, 4'b0011, 2'd3, 9'h110, 9'h120);
        cyc(1, ALL, D, 2'b00, 4'b1100, 2'd3, 9'h130, 9'h140);
        cyc(1, ALL, D, 2'b00, 4'b0011, 2'd3, 9'h110, 9'h120);

        cyc(1, 4'b1011, 32'h405A2010, 2'b00, 4'b0100, 2'd3, 9'h15A, NO);
        cyc(1, ALL, D, 2'b00, 4'b1001, 2'd3, 9'h140, 9'h110);

        cyc(1, ALL, D, 2'b01, 4'b0010, 2'd3, NO, 9'h120);
        cyc(1, ALL, D, 2'b01, 4'b0100, 2'd3, NO, 9'h130);
        cyc(1, ALL, D, 2'b01, 4'b1000, 2'd3, NO, 9'h140);
        cyc(1, ALL, D, 2'b01, 4'b0001, 2'd3, NO, 9'h110);
        cyc(1, ALL, D, 2'b11, 4'b0000, 2'd3, NO, NO);
        cyc(1, ALL, D, 2'b11, 4'b0000, 2'd3, NO, NO);
        cyc(1, NON, D, 2'b00, 4'b0000, 2'd3, NO, NO);

        cyc(1, ALL, D, 2'b00, 4'b0110, 2'd3, 9'h120, 9'h130);
        cyc(0, ALL, D, 2'b00, 4'b1001, 2'd3, 9'h140, 9'h110);
        cyc(0, ALL, D, 2'b00, 4'b0000, 2'd2, NO, NO);
        cyc(1, ALL, D, 2'b00, 4'b0000, 2'd2, NO, NO);
        cyc(1, ALL, D, 2'b00, 4'b0110, 2'd3, 9'h120, 9'h130);
        cyc(1, ALL, D, 2'b00, 4'b1001, 2'd3, 9'h140, 9'h110);

        #5;
        reset = 1'b0;
        #1;
        chk_quiet("async_reset");
        q0.delete();
        q1.delete();
        @(posedge clk_2f);
        #1;
        reset = 1'b1;

        cyc(1, ALL, D, 2'b00, 4'b0000, 2'd0, NO, NO);
        for (int i = 0; i < 8; i++) cyc(1, ALL, D, 2'b00, 4'b0000, 2'd1, NO, NO);
        cyc(1, ALL, D, 2'b00, 4'b0011, 2'd3, 9'h110, 9'h120);
        cyc(1, NON, D, 2'b00, 4'b0000, 2'd3, NO, NO);
        cyc(1, NON, D, 2'b00, 4'b0000, 2'd3, NO, NO);

        chk("lane0_drained", q0.size(), 32'd0);
        chk("lane1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
